// File: rtl/MIDI.sv
// MIDI message definitions shared between the message decoder and the voice
// allocator. Only the status nibble and the two 7-bit data bytes are carried;
// the channel has already been filtered upstream.
package MIDI;

    localparam logic [3:0] NOTE_OFF       = 4'h8;
    localparam logic [3:0] NOTE_ON        = 4'h9;
    localparam logic [3:0] CONTROL_CHANGE = 4'hB;

    typedef struct packed {
        logic [3:0] message_type;
        logic [6:0] data_byte1;
        logic [6:0] data_byte2;
    } message_t;

endpackage

// File: rtl/voice_allocator.sv
// voice_allocator
// Polyphonic voice scheduler. Takes decoded NOTE_ON / NOTE_OFF / CONTROL_CHANGE
// messages and maps notes onto NUM_VOICES voice slots: retrigger of an already
// sounding note, otherwise the lowest free voice, otherwise the oldest voice is
// stolen. Handles damper pedal (CC 64) hold and all-notes-off (CC 123).
//
// Ports
//   clock_50_000_000 : system clock, all logic on posedge
//   reset            : synchronous active-high reset
//   message          : decoded MIDI message (type, data byte 1, data byte 2)
//   message_ready    : single-cycle strobe, message valid this cycle
//   voice_note       : 7-bit note per voice, voice i at [i*7 +: 7]
//   voice_velocity   : 7-bit velocity per voice, voice i at [i*7 +: 7]
//   voice_gate       : per-voice gate (key or pedal held)
//   voice_trigger    : per-voice 1-cycle attack (re)start pulse
//   voice_release    : per-voice 1-cycle pulse when the gate falls
//   voice_steal      : 1-cycle pulse when a note-on stole a gated voice
//   pedal_down       : current damper pedal state
//
// All outputs are registered and reflect a message on the cycle after its
// message_ready.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int RANK_W     = $clog2(NUM_VOICES)
) (
    input  logic                      clock_50_000_000,
    input  logic                      reset,
    input  MIDI::message_t            message,
    input  logic                      message_ready,
    output logic [NUM_VOICES*7-1:0]   voice_note,
    output logic [NUM_VOICES*7-1:0]   voice_velocity,
    output logic [NUM_VOICES-1:0]     voice_gate,
    output logic [NUM_VOICES-1:0]     voice_trigger,
    output logic [NUM_VOICES-1:0]     voice_release,
    output logic                      voice_steal,
    output logic                      pedal_down
);

    localparam logic [RANK_W-1:0] OLDEST = RANK_W'(NUM_VOICES - 1);

    // Isolates the lowest set bit, giving lowest-index priority as a one-hot.
    function automatic logic [NUM_VOICES-1:0] lowest(input logic [NUM_VOICES-1:0] x);
        return x & (~x + NUM_VOICES'(1));
    endfunction

    logic is_note_on;
    logic is_note_off;
    logic is_cc_pedal;
    logic is_cc_all_off;
    logic pedal_up;

    logic pedal_reg;
    logic steal_reg;
    logic steal_next;

    logic [NUM_VOICES-1:0]        match_on;   // gated voice playing this note
    logic [NUM_VOICES-1:0]        match_off;  // gated, not pedal-held, this note
    logic [NUM_VOICES-1:0]        free_v;
    logic [NUM_VOICES-1:0]        oldest_v;
    logic [NUM_VOICES-1:0]        held_v;
    logic [NUM_VOICES-1:0]        on_sel;     // one-hot target of a note-on
    logic [NUM_VOICES-1:0]        off_sel;    // one-hot target of a note-off
    logic [NUM_VOICES*RANK_W-1:0] rank_flat;
    logic [RANK_W-1:0]            sel_rank;   // pre-update rank of on_sel voice

    // ------------------------------------------------------------------
    // Message classification
    // ------------------------------------------------------------------
    always_comb begin
        is_note_on    = message_ready
                        && (message.message_type == MIDI::NOTE_ON)
                        && (message.data_byte2 != 7'd0);
        // A note-on with zero velocity is the running-status form of note-off.
        is_note_off   = message_ready
                        && ((message.message_type == MIDI::NOTE_OFF)
                            || ((message.message_type == MIDI::NOTE_ON)
                                && (message.data_byte2 == 7'd0)));
        is_cc_pedal   = message_ready
                        && (message.message_type == MIDI::CONTROL_CHANGE)
                        && (message.data_byte1 == 7'd64);
        is_cc_all_off = message_ready
                        && (message.message_type == MIDI::CONTROL_CHANGE)
                        && (message.data_byte1 == 7'd123);
        // Only a real down-to-up transition flushes the held voices.
        pedal_up      = is_cc_pedal && pedal_reg && !message.data_byte2[6];
    end

    // ------------------------------------------------------------------
    // Voice selection on registered state
    // ------------------------------------------------------------------
    always_comb begin
        if (|match_on) begin
            on_sel = lowest(match_on);
        end else if (|free_v) begin
            on_sel = lowest(free_v);
        end else begin
            // Ranks are a permutation, so exactly one voice is oldest.
            on_sel = oldest_v;
        end
        steal_next = is_note_on && !(|match_on) && !(|free_v);
        off_sel    = lowest(match_off);

        sel_rank = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (on_sel[i]) begin
                sel_rank = sel_rank | rank_flat[i*RANK_W +: RANK_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Global state
    // ------------------------------------------------------------------
    always_ff @(posedge clock_50_000_000) begin
        if (reset) begin
            pedal_reg <= 1'b0;
            steal_reg <= 1'b0;
        end else begin
            steal_reg <= steal_next;
            if (is_cc_pedal) begin
                pedal_reg <= message.data_byte2[6];
            end
        end
    end

    assign pedal_down  = pedal_reg;
    assign voice_steal = steal_reg;

    // ------------------------------------------------------------------
    // Per-voice state
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            logic [6:0]        note_reg;
            logic [6:0]        vel_reg;
            logic              gate_reg;
            logic              held_reg;
            logic              trig_reg;
            logic              rel_reg;
            logic [RANK_W-1:0] rank_reg;

            assign match_on[gi]  = gate_reg && (note_reg == message.data_byte1);
            assign match_off[gi] = match_on[gi] && !held_reg;
            assign free_v[gi]    = !gate_reg;
            assign oldest_v[gi]  = (rank_reg == OLDEST);
            assign held_v[gi]    = held_reg;
            assign rank_flat[gi*RANK_W +: RANK_W] = rank_reg;

            assign voice_note[gi*7 +: 7]     = note_reg;
            assign voice_velocity[gi*7 +: 7] = vel_reg;
            assign voice_gate[gi]            = gate_reg;
            assign voice_trigger[gi]         = trig_reg;
            assign voice_release[gi]         = rel_reg;

            always_ff @(posedge clock_50_000_000) begin
                if (reset) begin
                    note_reg <= 7'd0;
                    vel_reg  <= 7'd0;
                    gate_reg <= 1'b0;
                    held_reg <= 1'b0;
                    trig_reg <= 1'b0;
                    rel_reg  <= 1'b0;
                    rank_reg <= RANK_W'(gi);
                end else begin
                    trig_reg <= 1'b0;
                    rel_reg  <= 1'b0;
                    if (is_note_on) begin
                        if (on_sel[gi]) begin
                            // Retrigger, fresh allocation and steal all land
                            // here; a stolen voice keeps its gate high and
                            // gets no release pulse.
                            note_reg <= message.data_byte1;
                            vel_reg  <= message.data_byte2;
                            gate_reg <= 1'b1;
                            held_reg <= 1'b0;
                            trig_reg <= 1'b1;
                            rank_reg <= '0;
                        end else if (rank_reg < sel_rank) begin
                            // Voices newer than the selected one age by one,
                            // keeping the ranks a permutation.
                            rank_reg <= rank_reg + RANK_W'(1);
                        end
                    end else if (is_note_off) begin
                        if (off_sel[gi]) begin
                            if (pedal_reg) begin
                                held_reg <= 1'b1;
                            end else begin
                                gate_reg <= 1'b0;
                                rel_reg  <= 1'b1;
                            end
                        end
                    end else if (is_cc_all_off) begin
                        if (gate_reg) begin
                            rel_reg <= 1'b1;
                        end
                        gate_reg <= 1'b0;
                        held_reg <= 1'b0;
                    end else if (pedal_up && held_reg) begin
                        gate_reg <= 1'b0;
                        rel_reg  <= 1'b1;
                        held_reg <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    // held_v is kept as a flat view of the pedal-held voices for debug probes.
    logic unused_held;
    assign unused_held = ^held_v;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed testbench for voice_allocator (4 voices). Each task drives a
// scenario and compares the registered outputs one cycle after each message.
module tb_voice_allocator;

    localparam int NV = 4;

    logic                clk;
    logic                reset;
    MIDI::message_t      message;
    logic                message_ready;
    logic [NV*7-1:0]     voice_note;
    logic [NV*7-1:0]     voice_velocity;
    logic [NV-1:0]       voice_gate;
    logic [NV-1:0]       voice_trigger;
    logic [NV-1:0]       voice_release;
    logic                voice_steal;
    logic                pedal_down;

    int n_checks = 0;
    int n_errors = 0;

    voice_allocator #(.NUM_VOICES(NV)) dut (
        .clock_50_000_000 (clk),
        .reset            (reset),
        .message          (message),
        .message_ready    (message_ready),
        .voice_note       (voice_note),
        .voice_velocity   (voice_velocity),
        .voice_gate       (voice_gate),
        .voice_trigger    (voice_trigger),
        .voice_release    (voice_release),
        .voice_steal      (voice_steal),
        .pedal_down       (pedal_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one message for one cycle; returns 1 time unit after the edge
    // that captured it, where its effect is visible on the outputs.
    task automatic send(input logic [3:0] t, input logic [6:0] d1, input logic [6:0] d2);
        @(negedge clk);
        message.message_type = t;
        message.data_byte1   = d1;
        message.data_byte2   = d2;
        message_ready        = 1'b1;
        @(posedge clk);
        #1;
        message_ready = 1'b0;
        $display("msg type=%h d1=%0d d2=%0d -> gate=%b trig=%b rel=%b steal=%b pedal=%b",
                 t, d1, d2, voice_gate, voice_trigger, voice_release, voice_steal, pedal_down);
    endtask

    task automatic idle();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        message_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (voice_note !== '0) begin n_errors++; $display("FAIL reset_note: got %h expected 0", voice_note); end
        n_checks++;
        if (voice_velocity !== '0) begin n_errors++; $display("FAIL reset_vel: got %h expected 0", voice_velocity); end
        n_checks++;
        if ({voice_gate, voice_trigger, voice_release} !== '0) begin n_errors++;
            $display("FAIL reset_strobes: got gate=%b trig=%b rel=%b expected all 0", voice_gate, voice_trigger, voice_release); end
        n_checks++;
        if ({voice_steal, pedal_down} !== 2'b00) begin n_errors++;
            $display("FAIL reset_steal_pedal: got %b%b expected 00", voice_steal, pedal_down); end
    endtask

    task automatic test_alloc();
        do_reset();
        send(MIDI::NOTE_ON, 7'd60, 7'd100);
        n_checks++;
        if (voice_trigger !== 4'b0001) begin n_errors++; $display("FAIL alloc_trig0: got %b expected 0001", voice_trigger); end
        n_checks++;
        if (voice_note[6:0] !== 7'd60 || voice_velocity[6:0] !== 7'd100) begin n_errors++;
            $display("FAIL alloc_v0: got note %0d vel %0d expected 60/100", voice_note[6:0], voice_velocity[6:0]); end
        send(MIDI::NOTE_ON, 7'd64, 7'd90);
        n_checks++;
        if (voice_trigger !== 4'b0010) begin n_errors++; $display("FAIL alloc_trig1: got %b expected 0010", voice_trigger); end
        send(MIDI::NOTE_ON, 7'd67, 7'd80);
        n_checks++;
        if (voice_trigger !== 4'b0100) begin n_errors++; $display("FAIL alloc_trig2: got %b expected 0100", voice_trigger); end
        n_checks++;
        if (voice_gate !== 4'b0111) begin n_errors++; $display("FAIL alloc_gate: got %b expected 0111", voice_gate); end
        n_checks++;
        if (voice_note[20:0] !== {7'd67, 7'd64, 7'd60} || voice_velocity[20:0] !== {7'd80, 7'd90, 7'd100}) begin n_errors++;
            $display("FAIL alloc_notes: got note %h vel %h expected notes 60,64,67 vel 100,90,80", voice_note, voice_velocity); end
        idle();
        n_checks++;
        if (voice_trigger !== 4'b0000 || voice_steal !== 1'b0) begin n_errors++;
            $display("FAIL alloc_strobe_clear: got trig=%b steal=%b expected 0000/0", voice_trigger, voice_steal); end
    endtask

    // Continues from test_alloc: voices 0..2 gated, ranks v2=0 v1=1 v0=2 v3=3.
    task automatic test_steal();
        send(MIDI::NOTE_ON, 7'd71, 7'd70);
        n_checks++;
        if (voice_trigger !== 4'b1000 || voice_gate !== 4'b1111 || voice_steal !== 1'b0) begin n_errors++;
            $display("FAIL steal_fill: got trig=%b gate=%b steal=%b expected 1000/1111/0", voice_trigger, voice_gate, voice_steal); end
        send(MIDI::NOTE_ON, 7'd72, 7'd50);
        n_checks++;
        if (voice_trigger !== 4'b0001 || voice_steal !== 1'b1 || voice_release !== 4'b0000) begin n_errors++;
            $display("FAIL steal_oldest: got trig=%b steal=%b rel=%b expected 0001/1/0000", voice_trigger, voice_steal, voice_release); end
        n_checks++;
        if (voice_note[6:0] !== 7'd72 || voice_velocity[6:0] !== 7'd50 || voice_gate !== 4'b1111) begin n_errors++;
            $display("FAIL steal_v0: got note %0d vel %0d gate %b expected 72/50/1111", voice_note[6:0], voice_velocity[6:0], voice_gate); end
        // v0 is now newest, so the next oldest is v1.
        send(MIDI::NOTE_ON, 7'd73, 7'd40);
        n_checks++;
        if (voice_trigger !== 4'b0010 || voice_steal !== 1'b1) begin n_errors++;
            $display("FAIL steal_next: got trig=%b steal=%b expected 0010/1", voice_trigger, voice_steal); end
        idle();
        n_checks++;
        if (voice_steal !== 1'b0 || voice_trigger !== 4'b0000) begin n_errors++;
            $display("FAIL steal_pulse_width: got steal=%b trig=%b expected 0/0000", voice_steal, voice_trigger); end
    endtask

    task automatic test_retrigger();
        do_reset();
        send(MIDI::NOTE_ON, 7'd60, 7'd100);
        send(MIDI::NOTE_ON, 7'd64, 7'd90);
        send(MIDI::NOTE_ON, 7'd60, 7'd20);
        n_checks++;
        if (voice_trigger !== 4'b0001 || voice_steal !== 1'b0 || voice_gate !== 4'b0011) begin n_errors++;
            $display("FAIL retrig_same_voice: got trig=%b steal=%b gate=%b expected 0001/0/0011", voice_trigger, voice_steal, voice_gate); end
        n_checks++;
        if (voice_velocity[6:0] !== 7'd20) begin n_errors++;
            $display("FAIL retrig_vel: got %0d expected 20", voice_velocity[6:0]); end
        // Retrigger made v0 newest: ranks v0=0 v1=1; after 67 and 71, v1 is oldest.
        send(MIDI::NOTE_ON, 7'd67, 7'd80);
        send(MIDI::NOTE_ON, 7'd71, 7'd80);
        send(MIDI::NOTE_ON, 7'd72, 7'd80);
        n_checks++;
        if (voice_trigger !== 4'b0010 || voice_steal !== 1'b1) begin n_errors++;
            $display("FAIL retrig_rank: got trig=%b steal=%b expected 0010/1", voice_trigger, voice_steal); end
    endtask

    task automatic test_pedal();
        do_reset();
        send(MIDI::NOTE_ON, 7'd60, 7'd100);
        send(MIDI::CONTROL_CHANGE, 7'd64, 7'd127);
        n_checks++;
        if (pedal_down !== 1'b1) begin n_errors++; $display("FAIL pedal_down_set: got %b expected 1", pedal_down); end
        send(MIDI::NOTE_OFF, 7'd60, 7'd0);
        n_checks++;
        if (voice_gate !== 4'b0001 || voice_release !== 4'b0000) begin n_errors++;
            $display("FAIL pedal_hold: got gate=%b rel=%b expected 0001/0000", voice_gate, voice_release); end
        send(MIDI::CONTROL_CHANGE, 7'd64, 7'd100);
        n_checks++;
        if (voice_gate !== 4'b0001 || voice_release !== 4'b0000 || pedal_down !== 1'b1) begin n_errors++;
            $display("FAIL pedal_repeat: got gate=%b rel=%b pedal=%b expected 0001/0000/1", voice_gate, voice_release, pedal_down); end
        send(MIDI::CONTROL_CHANGE, 7'd64, 7'd0);
        n_checks++;
        if (voice_release !== 4'b0001 || voice_gate !== 4'b0000 || pedal_down !== 1'b0) begin n_errors++;
            $display("FAIL pedal_up_release: got rel=%b gate=%b pedal=%b expected 0001/0000/0", voice_release, voice_gate, pedal_down); end
        // Held note retriggered while pedal down: pedal-up must not release it.
        send(MIDI::NOTE_ON, 7'd60, 7'd100);
        send(MIDI::CONTROL_CHANGE, 7'd64, 7'd64);
        send(MIDI::NOTE_OFF, 7'd60, 7'd0);
        send(MIDI::NOTE_ON, 7'd60, 7'd50);
        n_checks++;
        if (voice_trigger !== 4'b0001 || voice_gate !== 4'b0001 || voice_velocity[6:0] !== 7'd50) begin n_errors++;
            $display("FAIL pedal_retrig: got trig=%b gate=%b vel=%0d expected 0001/0001/50", voice_trigger, voice_gate, voice_velocity[6:0]); end
        send(MIDI::CONTROL_CHANGE, 7'd64, 7'd63);
        n_checks++;
        if (voice_release !== 4'b0000 || voice_gate !== 4'b0001) begin n_errors++;
            $display("FAIL pedal_retrig_no_release: got rel=%b gate=%b expected 0000/0001", voice_release, voice_gate); end
    endtask

    task automatic test_note_off();
        do_reset();
        send(MIDI::NOTE_ON, 7'd60, 7'd100);
        send(MIDI::NOTE_ON, 7'd61, 7'd90);
        send(MIDI::NOTE_ON, 7'd60, 7'd0);
        n_checks++;
        if (voice_release !== 4'b0001 || voice_gate !== 4'b0010) begin n_errors++;
            $display("FAIL vel0_is_off: got rel=%b gate=%b expected 0001/0010", voice_release, voice_gate); end
        n_checks++;
        if (voice_note[6:0] !== 7'd60 || voice_velocity[6:0] !== 7'd100) begin n_errors++;
            $display("FAIL off_retains_pitch: got note %0d vel %0d expected 60/100", voice_note[6:0], voice_velocity[6:0]); end
        send(MIDI::NOTE_OFF, 7'd65, 7'd0);
        n_checks++;
        if (voice_release !== 4'b0000 || voice_gate !== 4'b0010 || voice_trigger !== 4'b0000
            || voice_note !== {7'd0, 7'd0, 7'd61, 7'd60}) begin n_errors++;
            $display("FAIL off_no_match: got rel=%b gate=%b trig=%b note=%h expected 0000/0010/0000/notes 60,61", voice_release, voice_gate, voice_trigger, voice_note); end
        // Ignored traffic: other CC numbers and other message types.
        send(MIDI::CONTROL_CHANGE, 7'd7, 7'd127);
        send(4'hA, 7'd61, 7'd10);
        n_checks++;
        if (voice_gate !== 4'b0010 || voice_trigger !== 4'b0000 || voice_release !== 4'b0000
            || pedal_down !== 1'b0 || voice_velocity[13:7] !== 7'd90) begin n_errors++;
            $display("FAIL ignored_msgs: got gate=%b trig=%b rel=%b pedal=%b vel1=%0d expected 0010/0000/0000/0/90", voice_gate, voice_trigger, voice_release, pedal_down, voice_velocity[13:7]); end
    endtask

    task automatic test_all_notes_off();
        do_reset();
        send(MIDI::NOTE_ON, 7'd60, 7'd100);
        send(MIDI::NOTE_ON, 7'd64, 7'd90);
        send(MIDI::NOTE_ON, 7'd67, 7'd80);
        send(MIDI::CONTROL_CHANGE, 7'd64, 7'd127);
        send(MIDI::NOTE_OFF, 7'd64, 7'd0);
        send(MIDI::CONTROL_CHANGE, 7'd123, 7'd0);
        n_checks++;
        if (voice_release !== 4'b0111 || voice_gate !== 4'b0000) begin n_errors++;
            $display("FAIL all_off: got rel=%b gate=%b expected 0111/0000", voice_release, voice_gate); end
        n_checks++;
        if (pedal_down !== 1'b1 || voice_note[20:0] !== {7'd67, 7'd64, 7'd60}) begin n_errors++;
            $display("FAIL all_off_retain: got pedal=%b note=%h expected 1/notes 60,64,67", pedal_down, voice_note); end
        send(MIDI::CONTROL_CHANGE, 7'd64, 7'd0);
        n_checks++;
        if (voice_release !== 4'b0000 || pedal_down !== 1'b0) begin n_errors++;
            $display("FAIL all_off_held_cleared: got rel=%b pedal=%b expected 0000/0", voice_release, pedal_down); end
    endtask

    task automatic test_reset_priority();
        do_reset();
        send(MIDI::NOTE_ON, 7'd50, 7'd100);
        @(negedge clk);
        reset = 1'b1;
        message.message_type = MIDI::NOTE_ON;
        message.data_byte1   = 7'd60;
        message.data_byte2   = 7'd100;
        message_ready        = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        message_ready = 1'b0;
        n_checks++;
        if (voice_gate !== 4'b0000 || voice_trigger !== 4'b0000 || voice_note !== '0 || voice_velocity !== '0) begin n_errors++;
            $display("FAIL reset_dominates: got gate=%b trig=%b note=%h vel=%h expected all 0", voice_gate, voice_trigger, voice_note, voice_velocity); end
        idle();
        n_checks++;
        if (voice_gate !== 4'b0000 || voice_trigger !== 4'b0000) begin n_errors++;
            $display("FAIL reset_no_alloc: got gate=%b trig=%b expected 0000/0000", voice_gate, voice_trigger); end
    endtask

    initial begin
        reset         = 1'b1;
        message_ready = 1'b0;
        message       = '0;
        test_reset();
        test_alloc();
        test_steal();
        test_retrigger();
        test_pedal();
        test_note_off();
        test_all_notes_off();
        test_reset_priority();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphonic voice scheduler between the MIDI message decoder and the per-voice oscillator/envelope datapath.
- Consumes NOTE_ON / NOTE_OFF / CONTROL_CHANGE messages.
- Assigns each note to one of NUM_VOICES voice slots, steals the oldest voice when all are busy, and implements damper-pedal (CC 64) hold and all-notes-off (CC 123).
- Drives per-voice note, velocity, gate and single-cycle trigger/release strobes to the envelope generators.

Parameters:
NUM_VOICES, 4, number of voice slots (2..8)
RANK_W, $clog2(NUM_VOICES), width of per-voice age rank

Ports:
clock_50_000_000  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
message  input  MIDI::message_t  decoded MIDI message (message_type, data_byte1, data_byte2)
message_ready  input  1  single-cycle strobe; message valid this cycle
voice_note  output  NUM_VOICES x 7  MIDI note number per voice
voice_velocity  output  NUM_VOICES x 7  velocity per voice
voice_gate  output  NUM_VOICES  1 = voice held (key or pedal)
voice_trigger  output  NUM_VOICES  1-cycle pulse: attack (re)start
voice_release  output  NUM_VOICES  1-cycle pulse: gate fell, start release
voice_steal  output  1  1-cycle pulse: last note-on stole a gated voice
pedal_down  output  1  current damper state

Behaviour:
- Reset (dominates message_ready):
  - voice_note, voice_velocity, voice_gate, voice_trigger, voice_release, voice_steal, pedal_down, held bits all 0.
  - rank[i] = i (voice 0 newest, voice NUM_VOICES-1 oldest).
- Latency: outputs reflect a message on the cycle after its message_ready. Strobes are high exactly one cycle, otherwise 0. No backpressure; one message per cycle is accepted.
- Message classification:
  - NOTE_ON with data_byte2 = 0 is treated as NOTE_OFF.
  - Non-note, non-CC types are ignored.
  - CC numbers other than 64/123 are ignored.
  - Message fields are sampled only when message_ready = 1.
- NOTE_ON n, v (v > 0), priority order:
  1. Match: some gated voice has voice_note = n. Retrigger that voice (lowest index if several): velocity <= v, trigger pulse, held bit cleared, gate stays 1.
  2. Free: else the lowest-index voice with gate = 0 gets note <= n, velocity <= v, gate <= 1, trigger pulse.
  3. Steal: else the voice with rank = NUM_VOICES-1 gets note/velocity overwritten, trigger pulse, voice_steal pulse. Gate stays 1, no release pulse, held bit cleared.
  - The selected voice always becomes newest: its rank <= 0; every voice with rank < the selected voice's old rank increments. Ranks remain a permutation of 0..NUM_VOICES-1.
- NOTE_OFF n:
  - Applies to the gated voice with voice_note = n and held = 0 (lowest index if several).
  - pedal_down = 0: gate <= 0, release pulse.
  - pedal_down = 1: held <= 1, gate stays 1, no pulse.
  - No match: ignored, no output change.
  - Ranks unchanged.
- CC 64: pedal_down <= (data_byte2 >= 64).
  - On a 1->0 transition, every voice with held = 1 gets gate <= 0, release pulse, held <= 0, all in the same cycle.
  - Repeated same-state CC 64 messages have no effect.
- CC 123 (all notes off):
  - Every gated voice gets gate <= 0 and a release pulse; all held bits clear.
  - pedal_down is unchanged. Ranks and note/velocity are unchanged.
- Note/velocity of a released voice are retained until reallocation, so the release tail keeps its pitch.
- Free-voice search and rank selection are combinational on registered state. Only one voice changes allocation per message.

Test Plan:
- Reset, then NOTE_ON 60/100, 64/90, 67/80 -> voices 0,1,2 get those notes; trigger pulses on 0,1,2 in successive cycles; voice_gate = 4'b0111; ranks v2 = 0, v1 = 1, v0 = 2.
- With 4 voices gated (60,64,67,71 in order), NOTE_ON 72/50 -> voice 0 (oldest) gets note 72; voice_trigger[0] and voice_steal pulse; no release pulse; v0 rank 0.
- NOTE_ON 60/100, then NOTE_ON 60/20 -> same voice retriggers with velocity 20; no second voice used; no steal.
- NOTE_ON 60, CC64 = 127, NOTE_OFF 60 -> gate stays 1, no release. CC64 = 0 -> release pulse on that voice, gate 0. A NOTE_ON 60 while held -> retrigger, and the later pedal-up produces no release.
- NOTE_ON 60/0 on a gated voice -> behaves as NOTE_OFF (release pulse). NOTE_OFF 61 with no match -> no outputs change.
- Three gated voices, CC 123 -> simultaneous release pulses on all three, gate = 0. Assert reset in the same cycle as a NOTE_ON message_ready -> all outputs 0 next cycle and the note is not allocated.
